// File: rtl/scan_inject_ctrl.sv
// Scan-inject sequencer: shifts a pattern into the scan chain, captures the old contents,
// then streams them out byte-wise over valid/ready. Define SCAN_INJECT_HDR_EN to prefix a 0xA5 header byte.
module scan_inject_ctrl #(
  parameter int CHAIN_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] inject_data,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
`ifdef SCAN_INJECT_HDR_EN
  localparam int NBYTES = CHAIN_LEN / 8 + 1;
  localparam int BYTE_W = $clog2(CHAIN_LEN / 8 + 2);
`else
  localparam int NBYTES = CHAIN_LEN / 8;
  localparam int BYTE_W = $clog2(CHAIN_LEN / 8 + 1);
`endif
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CHAIN_LEN - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DUMP, DONE} state_t;

  state_t               state, state_nxt;
  logic [CHAIN_LEN-1:0] sr, sr_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-1:0]    byte_cnt, byte_cnt_nxt;
  logic                 start_q;
  logic                 hdr_phase;

  // The header occupies byte slot 0 and leaves the captured data untouched.
`ifdef SCAN_INJECT_HDR_EN
  assign hdr_phase = (byte_cnt == '0);
`else
  assign hdr_phase = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      start_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      bit_cnt  <= bit_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      start_q  <= start;
    end
  end

  always_comb begin
    state_nxt    = state;
    sr_nxt       = sr;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    scan_en      = 1'b0;
    scan_in      = 1'b0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start && !start_q) begin
          sr_nxt       = inject_data;
          bit_cnt_nxt  = '0;
          byte_cnt_nxt = '0;
          state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        busy        = 1'b1;
        scan_en     = 1'b1;
        scan_in     = sr[0];
        sr_nxt      = {scan_out, sr[CHAIN_LEN-1:1]};
        bit_cnt_nxt = bit_cnt + 1'b1;
        if (bit_cnt == BIT_LAST) state_nxt = DUMP;
      end
      DUMP: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = hdr_phase ? 8'hA5 : sr[7:0];
        if (tx_ready) begin
          byte_cnt_nxt = byte_cnt + 1'b1;
          if (!hdr_phase) sr_nxt = sr >> 8;
          if (byte_cnt == BYTE_LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/scan_inject_ctrl.md
# scan_inject_ctrl

Sequencer for the scan-inject test datapath. On a start request it loads a CHAIN_LEN-bit inject pattern, shifts it into the design's scan chain, and captures the bits shifted out. It then streams the captured bits byte-by-byte to the serial transmitter over a valid/ready handshake. It sits between the switch/button front end and the UART TX in the top level.

## Interface
- CHAIN_LEN, 32, scan chain length in bits; must be a multiple of 8 and ≥ 8
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request level; a 0→1 transition in IDLE starts a run
- inject_data  in  CHAIN_LEN  pattern to shift in; sampled on the accepted start edge
- scan_en  out  1  scan chain shift enable
- scan_in  out  1  serial data into chain head
- scan_out  in  1  serial data from chain tail
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE → SHIFT → DUMP → DONE → IDLE.
- IDLE:
  - start_q registers start.
  - When start=1 and start_q=0: load shift register sr ← inject_data, clear bit counter, go to SHIFT.
  - Start edges while not in IDLE are ignored; start_q still updates.
- SHIFT:
  - scan_en=1 and scan_in=sr[0].
  - Each cycle: sr ← {scan_out, sr[CHAIN_LEN-1:1]}; bit counter +1.
  - After CHAIN_LEN shift cycles, go to DUMP. sr then holds the prior chain contents, LSB = first bit out, and the chain holds inject_data.
- DUMP:
  - tx_data = sr[7:0]; tx_valid=1.
  - On tx_valid & tx_ready: sr shifts right by 8 and the byte counter increments.
  - After CHAIN_LEN/8 accepted bytes, go to DONE. Bytes go out least-significant first.
- DONE: done=1 for one cycle, then IDLE.
- Counters: bit counter is $clog2(CHAIN_LEN+1) bits, byte counter is $clog2(CHAIN_LEN/8+1) bits. Neither wraps; both clear on entry to SHIFT.

## Timing
- Reset values: scan_en=0, scan_in=0, tx_data=0x00, tx_valid=0, busy=0, done=0. State is IDLE, sr=0, start_q=0.
- Asserting rst_n low in any state, including mid-SHIFT or mid-DUMP, returns to IDLE immediately. The partial chain contents are abandoned and no done pulse is generated.
- Start edge seen at edge N: scan_en is high from N+1 through N+CHAIN_LEN, exactly CHAIN_LEN cycles.
- First tx_valid at N+CHAIN_LEN+1.
- scan_out is sampled on the same edge the chain shifts, so it is the chain tail value before that edge.
- Handshake:
  - tx_valid is never deasserted without an accepting tx_ready.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - tx_valid drops in the cycle after the final acceptance.
- With tx_ready held at 1, one byte is transferred per cycle. A run takes CHAIN_LEN + CHAIN_LEN/8 + 1 cycles from the start edge to done (+1 with the header enabled).
- busy rises at N+1 and falls the cycle after done.
- done and tx_valid are never high together.

## Configuration
- SCAN_INJECT_HDR_EN:
  - Defined: DUMP first sends the header byte 0xA5, with the same handshake rules, before the captured bytes. The byte counter target is CHAIN_LEN/8+1.
  - Undefined: there is no header byte; only the captured bytes are sent.

## Test plan
- CHAIN_LEN=16, chain model preloaded 0x1234, inject_data=0xBEEF, tx_ready=1, start edge → scan_en high 16 cycles; bytes 0x34 then 0x12; chain model reads 0xBEEF; done pulses once.
- Same run with tx_ready low for 5 cycles at the first byte → tx_valid stays 1 and tx_data holds 0x34 all 5 cycles. The byte is accepted when tx_ready rises; there is no duplicate and no drop.
- Start toggled 0→1→0→1 during SHIFT → no second run; exactly 2 bytes sent and one done pulse.
- rst_n low at SHIFT cycle 7 → all outputs go to reset values asynchronously. Next start edge with inject_data=0x00FF → full 16-cycle shift; chain model reads 0x00FF.
- start held high continuously from reset → exactly one run. A second run occurs only after start returns to 0 and rises again.
- SCAN_INJECT_HDR_EN defined, chain model preloaded 0xCAFE → bytes 0xA5, 0xFE, 0xCA in order, then done.
